fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_pkg.sv | 9 +
 rtl/ifq_mem.sv | 17 +
 rtl/fetch_decode_queue.sv | 64 ++++++
 tb/tb_fetch_decode_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the fetch/decode boundary
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int REG_W = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB = 7;
endpackage

// File: rtl/ifq_mem.sv
// ifq_mem: queue storage, one write port and one asynchronous read port
module ifq_mem #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [2*XLEN-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [2*XLEN-1:0]        rdata
);
  logic [2*XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction queue between fetch and decode
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [XLEN-1:0]            out_instr,
  output logic [REG_W-1:0]           rs1_addr,
  output logic [REG_W-1:0]           rs2_addr,
  output logic [REG_W-1:0]           rd_addr,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [2*XLEN-1:0] rdata;
  logic push, pop;
  assign in_ready = !rst && (count != CW'(DEPTH)) && !flush;
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  ifq_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata({in_pc, in_instr}),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  // an empty queue shows a NOP at PC 0 so decode never sees stale storage
  assign out_instr = out_valid ? rdata[XLEN-1:0] : NOP_INSTR;
  assign out_pc = out_valid ? rdata[2*XLEN-1:XLEN] : '0;
  assign out_pc_plus4 = out_pc + XLEN'(4);
  assign rs1_addr = out_instr[RS1_LSB +: REG_W];
  assign rs2_addr = out_instr[RS2_LSB +: REG_W];
  assign rd_addr = out_instr[RD_LSB +: REG_W];
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed vectors plus a cycle-level queue scoreboard
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, out_pc_plus4, out_instr;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [2:0] count;
  int checks = 0, failures = 0;

  fetch_decode_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .out_instr(out_instr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0], 16'h0593};
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t q[$];
  logic s_push = 0, s_pop = 0, s_flush = 0;
  ent_t s_ent;

  always @(negedge clk) begin
    bit e_ir, e_ov;
    logic [31:0] e_pc, e_in;
    e_ir = !rst && q.size() < DEPTH && !flush;
    e_ov = q.size() != 0;
    e_pc = e_ov ? q[0].pc : 32'h0;
    e_in = e_ov ? q[0].instr : NOP;
    check("sb_in_ready", 64'(in_ready), 64'(e_ir));
    check("sb_out_valid", 64'(out_valid), 64'(e_ov));
    check("sb_count", 64'(count), 64'(q.size()));
    check("sb_out_pc", 64'(out_pc), 64'(e_pc));
    check("sb_out_instr", 64'(out_instr), 64'(e_in));
    check("sb_pc_plus4", 64'(out_pc_plus4), 64'(32'(e_pc + 32'd4)));
    check("sb_rs1", 64'(rs1_addr), 64'(e_in[19:15]));
    check("sb_rs2", 64'(rs2_addr), 64'(e_in[24:20]));
    check("sb_rd", 64'(rd_addr), 64'(e_in[11:7]));
    s_push = e_ir && in_valid;
    s_pop = e_ov && out_ready;
    s_flush = flush;
    s_ent = '{in_pc, in_instr};
  end

  always @(posedge clk) begin
    if (rst || s_flush) q.delete();
    else begin
      if (s_pop) void'(q.pop_front());
      if (s_push) q.push_back(s_ent);
    end
    s_push = 0;
    s_pop = 0;
    s_flush = 0;
  end

  always @(posedge rst) begin
    q.delete();
    s_push = 0;
    s_pop = 0;
    s_flush = 0;
  end

  typedef struct {
    logic iv; logic [31:0] pc; logic fl; logic ordy;
    logic e_ir; logic e_ov; int e_cnt; logic [31:0] e_pc;
  } vec_t;

  task automatic drive(input logic iv, input logic [31:0] pc, input logic fl, input logic ordy);
    in_valid = iv;
    in_pc = pc;
    in_instr = mk_instr(pc);
    flush = fl;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v[15];
    v[0]  = '{0, 32'h000, 0, 0, 1, 0, 0, 32'h000};
    v[1]  = '{1, 32'h100, 0, 0, 1, 0, 0, 32'h000};
    v[2]  = '{1, 32'h104, 0, 0, 1, 1, 1, 32'h100};
    v[3]  = '{1, 32'h108, 0, 0, 1, 1, 2, 32'h100};
    v[4]  = '{1, 32'h10C, 0, 0, 1, 1, 3, 32'h100};
    v[5]  = '{1, 32'h110, 0, 0, 0, 1, 4, 32'h100};
    v[6]  = '{0, 32'h000, 0, 1, 0, 1, 4, 32'h100};
    v[7]  = '{0, 32'h000, 0, 1, 1, 1, 3, 32'h104};
    v[8]  = '{0, 32'h000, 0, 1, 1, 1, 2, 32'h108};
    v[9]  = '{0, 32'h000, 0, 1, 1, 1, 1, 32'h10C};
    v[10] = '{1, 32'h110, 0, 0, 1, 0, 0, 32'h000};
    v[11] = '{1, 32'h114, 0, 0, 1, 1, 1, 32'h110};
    v[12] = '{1, 32'h118, 1, 0, 0, 1, 2, 32'h110};
    v[13] = '{0, 32'h000, 0, 0, 1, 0, 0, 32'h000};
    v[14] = '{0, 32'h000, 0, 1, 1, 0, 0, 32'h000};
    next_cycle();
    next_cycle();
    rst = 0;
    check("reset_rd_addr", 64'(rd_addr), 64'(0));
    check("reset_instr", 64'(out_instr), 64'(NOP));
    for (int i = 0; i < 15; i++) begin
      drive(v[i].iv, v[i].pc, v[i].fl, v[i].ordy);
      #3;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(v[i].e_ir));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(v[i].e_ov));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(v[i].e_cnt));
      check($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(v[i].e_pc));
      if (v[i].e_ov)
        check($sformatf("vec%0d_pc_plus4", i), 64'(out_pc_plus4), 64'(v[i].e_pc + 32'd4));
      next_cycle();
    end
    // steady-state streaming: one in, one out, pointers wrap several times
    drive(1, 32'h200, 0, 0);
    next_cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 32'h200 + 32'(i * 4), 0, 1);
      #3;
      check($sformatf("stream%0d_count", i), 64'(count), 64'(1));
      check($sformatf("stream%0d_pc", i), 64'(out_pc), 64'(32'h200 + 32'((i - 1) * 4)));
      next_cycle();
    end
    drive(0, 0, 0, 1);
    next_cycle();
    // PC + 4 wraps to zero at the top of the address space
    drive(1, 32'hFFFF_FFFC, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0);
    #3;
    check("wrap_pc_plus4", 64'(out_pc_plus4), 64'(0));
    next_cycle();
    drive(0, 0, 0, 1);
    next_cycle();
    // reset pulse between edges with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 0, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0);
    #1;
    check("pre_rst_count", 64'(count), 64'(3));
    rst = 1;
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(NOP));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    #1;
    rst = 0;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("post_rst%0d_out_valid", i), 64'(out_valid), 64'(0));
      next_cycle();
    end
    drive(1, 32'h400, 0, 0);
    next_cycle();
    drive(0, 0, 0, 1);
    #1;
    check("post_rst_new_pc", 64'(out_pc), 64'(32'h400));
    next_cycle();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
